// File: rtl/banked_register_file_if.sv
// ---------------------------------------------------------------------------
// banked_register_file_if
//
// Bundles the decode-side read signals, the writeback-side write signals and
// the clear/ready control of the banked register file.
//
//   rf_clear_req        : pulse that restarts the clear sweep
//   rf_ready            : file cleared and accepting writes
//   ds_read_sel         : per-port read index, port i at [i*IDX_WIDTH +: IDX_WIDTH]
//   ds_read_en          : per-port read enable
//   rf_read_value       : per-port read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wb_writeback_reg    : write index (thread id in the upper bits)
//   wb_writeback_value  : write data
//   wb_enable_writeback : write strobe
//
// master : the pipeline side (decode + writeback)
// slave  : the register file
// ---------------------------------------------------------------------------
interface banked_register_file_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_READ_PORTS = 2,
    parameter int IDX_WIDTH      = 7
);
    logic                                rf_clear_req;
    logic                                rf_ready;
    logic [NUM_READ_PORTS*IDX_WIDTH-1:0] ds_read_sel;
    logic [NUM_READ_PORTS-1:0]           ds_read_en;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rf_read_value;
    logic [IDX_WIDTH-1:0]                wb_writeback_reg;
    logic [DATA_WIDTH-1:0]               wb_writeback_value;
    logic                                wb_enable_writeback;

    modport master (
        output rf_clear_req,
        output ds_read_sel,
        output ds_read_en,
        output wb_writeback_reg,
        output wb_writeback_value,
        output wb_enable_writeback,
        input  rf_ready,
        input  rf_read_value
    );

    modport slave (
        input  rf_clear_req,
        input  ds_read_sel,
        input  ds_read_en,
        input  wb_writeback_reg,
        input  wb_writeback_value,
        input  wb_enable_writeback,
        output rf_ready,
        output rf_read_value
    );
endinterface

// File: rtl/banked_register_file.sv
// ---------------------------------------------------------------------------
// banked_register_file
//
// Multi-threaded register file with NUM_READ_PORTS registered read ports and
// one writeback port. After reset, or on rf_clear_req, a hardware sweep
// zeroes every entry one per cycle; rf_ready is high once the sweep is done.
//
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : asynchronous, active-low reset
//   bus   : banked_register_file_if.slave (read/write/clear signals)
//
// Build option:
//   REGFILE_BYPASS_EN : when defined, a write in the same cycle as a read of
//                       the same index forwards the new value to that port;
//                       otherwise the read returns the pre-write contents.
// ---------------------------------------------------------------------------
module banked_register_file #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_THREADS     = 4,
    parameter int REGS_PER_THREAD = 32,
    parameter int NUM_READ_PORTS  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    banked_register_file_if.slave   bus
);
    localparam int TOTAL_REGS = NUM_THREADS * REGS_PER_THREAD;
    localparam int IDX_WIDTH  = $clog2(TOTAL_REGS);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX     = IDX_WIDTH'(TOTAL_REGS - 1);
    localparam logic [IDX_WIDTH:0]   TOTAL_REGS_W = (IDX_WIDTH + 1)'(TOTAL_REGS);

    typedef enum logic {CLEARING, READY} state_t;

    state_t                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   clear_idx_q, clear_idx_d;
    logic [DATA_WIDTH-1:0]  registers [TOTAL_REGS];
    logic                   wr_fire;
    logic [DATA_WIDTH-1:0]  rd_data_p1 [NUM_READ_PORTS];

    // Indices beyond TOTAL_REGS only exist when TOTAL_REGS is not a power of two.
    function automatic logic idx_in_range(input logic [IDX_WIDTH-1:0] idx);
        return ({1'b0, idx} < TOTAL_REGS_W);
    endfunction

    // A writeback only lands in READY, and a clear request in the same cycle wins.
    assign wr_fire = (state_q == READY) && bus.wb_enable_writeback &&
                     !bus.rf_clear_req && idx_in_range(bus.wb_writeback_reg);

    assign bus.rf_ready = (state_q == READY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= CLEARING;
            clear_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        unique case (state_q)
            CLEARING: begin
                if (bus.rf_clear_req) begin
                    clear_idx_d = '0;
                end else if (clear_idx_q == LAST_IDX) begin
                    state_d     = READY;
                    clear_idx_d = '0;
                end else begin
                    clear_idx_d = clear_idx_q + IDX_WIDTH'(1);
                end
            end
            READY: begin
                if (bus.rf_clear_req) begin
                    state_d     = CLEARING;
                    clear_idx_d = '0;
                end
            end
            default: begin
                state_d     = CLEARING;
                clear_idx_d = '0;
            end
        endcase
    end

    // Storage carries no reset; the sweep defines its contents before READY.
    always_ff @(posedge clk) begin
        if (state_q == CLEARING) begin
            registers[clear_idx_q] <= '0;
        end else if (wr_fire) begin
            registers[bus.wb_writeback_reg] <= bus.wb_writeback_value;
        end
    end

    for (genvar i = 0; i < NUM_READ_PORTS; i++) begin : g_rd
        logic [IDX_WIDTH-1:0]  sel_p0;
        logic [DATA_WIDTH-1:0] data_p0;

        assign sel_p0 = bus.ds_read_sel[i*IDX_WIDTH +: IDX_WIDTH];

        // Reads during the sweep return 0 so partially cleared contents never leak.
        always_comb begin
            data_p0 = '0;
            if ((state_q == READY) && idx_in_range(sel_p0)) begin
                data_p0 = registers[sel_p0];
`ifdef REGFILE_BYPASS_EN
                if (wr_fire && (bus.wb_writeback_reg == sel_p0)) begin
                    data_p0 = bus.wb_writeback_value;
                end
`endif
            end
        end

        // ---- stage p0 -> p1 : registered read data ----
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rd_data_p1[i] <= '0;
            end else if (bus.ds_read_en[i]) begin
                rd_data_p1[i] <= data_p0;
            end
        end

        assign bus.rf_read_value[i*DATA_WIDTH +: DATA_WIDTH] = rd_data_p1[i];
    end

endmodule

// File: tb/tb_banked_register_file.sv
module tb_banked_register_file;
    localparam int DATA_WIDTH      = 32;
    localparam int NUM_THREADS     = 4;
    localparam int REGS_PER_THREAD = 32;
    localparam int NUM_READ_PORTS  = 2;
    localparam int TOTAL_REGS      = NUM_THREADS * REGS_PER_THREAD;
    localparam int IDX_WIDTH       = $clog2(TOTAL_REGS);

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    banked_register_file_if #(
        .DATA_WIDTH    (DATA_WIDTH),
        .NUM_READ_PORTS(NUM_READ_PORTS),
        .IDX_WIDTH     (IDX_WIDTH)
    ) bus ();

    banked_register_file #(
        .DATA_WIDTH     (DATA_WIDTH),
        .NUM_THREADS    (NUM_THREADS),
        .REGS_PER_THREAD(REGS_PER_THREAD),
        .NUM_READ_PORTS (NUM_READ_PORTS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Reference model: architectural contents, cycles left until ready,
    // and the value each read port should currently show.
    logic [DATA_WIDTH-1:0] mem_m [TOTAL_REGS];
    int                    sweep_left;
    logic [DATA_WIDTH-1:0] rd_m  [NUM_READ_PORTS];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [DATA_WIDTH-1:0] got,
                         input logic [DATA_WIDTH-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_WIDTH-1:0] port_out(input int p);
        return bus.rf_read_value[p*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < TOTAL_REGS; r++) mem_m[r] = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) rd_m[p] = '0;
        sweep_left = TOTAL_REGS;
    endtask

    task automatic idle();
        bus.rf_clear_req        = 1'b0;
        bus.ds_read_sel         = '0;
        bus.ds_read_en          = '0;
        bus.wb_writeback_reg    = '0;
        bus.wb_writeback_value  = '0;
        bus.wb_enable_writeback = 1'b0;
    endtask

    task automatic set_rd(input int p, input int idx, input bit en);
        bus.ds_read_sel[p*IDX_WIDTH +: IDX_WIDTH] = IDX_WIDTH'(idx);
        bus.ds_read_en[p] = en;
    endtask

    task automatic set_wr(input bit en, input int idx, input logic [DATA_WIDTH-1:0] v);
        bus.wb_enable_writeback = en;
        bus.wb_writeback_reg    = IDX_WIDTH'(idx);
        bus.wb_writeback_value  = v;
    endtask

    // One clock: predict from the pre-edge inputs, advance, then compare.
    task automatic tick();
        bit                    ready_b, wr_fire, clr;
        int                    widx;
        logic [DATA_WIDTH-1:0] wval;
        logic [DATA_WIDTH-1:0] nxt [NUM_READ_PORTS];
        int                    sel;
        ready_b = (sweep_left == 0);
        clr     = bus.rf_clear_req;
        widx    = int'(bus.wb_writeback_reg);
        wval    = bus.wb_writeback_value;
        wr_fire = ready_b && bus.wb_enable_writeback && !clr;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            nxt[p] = rd_m[p];
            if (bus.ds_read_en[p]) begin
                sel = int'(bus.ds_read_sel[p*IDX_WIDTH +: IDX_WIDTH]);
                if (!ready_b) nxt[p] = '0;
                else begin
                    nxt[p] = mem_m[sel];
`ifdef REGFILE_BYPASS_EN
                    if (wr_fire && widx == sel) nxt[p] = wval;
`endif
                end
            end
        end
        @(posedge clk);
        #1;
        if (!reset) begin
            model_reset();
        end else begin
            for (int p = 0; p < NUM_READ_PORTS; p++) rd_m[p] = nxt[p];
            if (wr_fire) mem_m[widx] = wval;
            if (clr) begin
                sweep_left = TOTAL_REGS;
                for (int r = 0; r < TOTAL_REGS; r++) mem_m[r] = '0;
            end else if (sweep_left > 0) begin
                sweep_left--;
            end
        end
        check("rf_ready", DATA_WIDTH'(bus.rf_ready), DATA_WIDTH'(sweep_left == 0));
        for (int p = 0; p < NUM_READ_PORTS; p++)
            check($sformatf("rd%0d", p), port_out(p), rd_m[p]);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        model_reset();
        #12;
        check("rst_ready", DATA_WIDTH'(bus.rf_ready), '0);
        check("rst_rd0", port_out(0), '0);
        check("rst_rd1", port_out(1), '0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Initial sweep: ready rises at edge 128 after release.
        for (int c = 1; c <= TOTAL_REGS + 2; c++) begin
            tick();
            if (c == TOTAL_REGS - 1) check("init_not_ready", DATA_WIDTH'(bus.rf_ready), '0);
            if (c == TOTAL_REGS)     check("init_ready", DATA_WIDTH'(bus.rf_ready), 1);
        end

        set_rd(0, 77, 1'b1);
        tick();
        check("rd77_zero", port_out(0), 32'h0000_0000);

        // Write then dual-port read of the same index.
        idle();
        set_wr(1'b1, 5, 32'hDEADBEEF);
        tick();
        idle();
        set_rd(0, 5, 1'b1);
        set_rd(1, 5, 1'b1);
        tick();
        check("wr5_p0", port_out(0), 32'hDEADBEEF);
        check("wr5_p1", port_out(1), 32'hDEADBEEF);

        // Read-during-write.
        idle();
        set_wr(1'b1, 9, 32'h11111111);
        tick();
        set_wr(1'b1, 9, 32'h22222222);
        set_rd(0, 9, 1'b1);
        tick();
`ifdef REGFILE_BYPASS_EN
        check("rdw9", port_out(0), 32'h22222222);
`else
        check("rdw9", port_out(0), 32'h11111111);
`endif
        idle();
        set_rd(0, 9, 1'b1);
        tick();
        check("rdw9_after", port_out(0), 32'h22222222);

        // Port 1 holds while disabled; port 0 keeps tracking.
        idle();
        set_wr(1'b1, 10, 32'hCAFE0001);
        tick();
        for (int k = 0; k < 4; k++) begin
            set_wr(1'b1, 11 + k, 32'h0000_0100 + k);
            tick();
        end
        idle();
        set_rd(1, 10, 1'b1);
        tick();
        check("hold_load", port_out(1), 32'hCAFE0001);
        for (int k = 0; k < 4; k++) begin
            set_rd(0, 11 + k, 1'b1);
            set_rd(1, 20 + k, 1'b0);
            tick();
            check("hold_p1", port_out(1), 32'hCAFE0001);
            check("track_p0", port_out(0), 32'h0000_0100 + k);
        end

        // Clear request, write during the sweep is dropped.
        idle();
        set_wr(1'b1, 3, 32'h00001234);
        tick();
        idle();
        bus.rf_clear_req = 1'b1;
        tick();
        check("clr_fall", DATA_WIDTH'(bus.rf_ready), '0);
        bus.rf_clear_req = 1'b0;
        for (int c = 1; c <= TOTAL_REGS; c++) begin
            if (c == 1) set_wr(1'b1, 3, 32'h00005555);
            else        idle();
            tick();
            if (c == TOTAL_REGS - 1) check("clr_not_ready", DATA_WIDTH'(bus.rf_ready), '0);
            if (c == TOTAL_REGS)     check("clr_ready", DATA_WIDTH'(bus.rf_ready), 1);
        end
        idle();
        set_rd(0, 3, 1'b1);
        tick();
        check("clr_rd3", port_out(0), 32'h0000_0000);

        // Reset in the middle of a sweep.
        idle();
        bus.rf_clear_req = 1'b1;
        tick();
        idle();
        repeat (40) tick();
        reset = 1'b0;
        #1;
        check("midrst_ready", DATA_WIDTH'(bus.rf_ready), '0);
        check("midrst_rd1", port_out(1), '0);
        model_reset();
        repeat (5) tick();
        reset = 1'b1;
        for (int c = 1; c <= TOTAL_REGS; c++) begin
            tick();
            if (c == TOTAL_REGS - 1) check("rel_not_ready", DATA_WIDTH'(bus.rf_ready), '0);
            if (c == TOTAL_REGS)     check("rel_ready", DATA_WIDTH'(bus.rf_ready), 1);
        end

        // Randomized traffic, concentrated on a few indices to provoke collisions.
        for (int c = 0; c < 3000; c++) begin
            int lim;
            lim = ($urandom_range(0, 3) == 0) ? TOTAL_REGS - 1 : 15;
            set_wr($urandom_range(0, 1) == 1, $urandom_range(0, lim), $urandom);
            for (int p = 0; p < NUM_READ_PORTS; p++)
                set_rd(p, $urandom_range(0, lim), $urandom_range(0, 2) != 0);
            bus.rf_clear_req = ($urandom_range(0, 299) == 0);
            reset = ($urandom_range(0, 1499) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
